// File: rtl/branch_tag_dispatch.sv
// Rename-stage entry register: takes a 4-wide group from the instruction buffer,
// hands each branch slot a checkpoint tag from a free pool, and back-pressures the buffer.
module branch_tag_dispatch #(
  parameter int PKT_W    = 96,
  parameter int NUM_TAGS = 8,
  parameter int TAG_LOG  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 ibReady_i,
  input  logic [PKT_W-1:0]     packet0_i,
  input  logic [PKT_W-1:0]     packet1_i,
  input  logic [PKT_W-1:0]     packet2_i,
  input  logic [PKT_W-1:0]     packet3_i,
  input  logic [3:0]           branchMask_i,
  input  logic                 stallBackEnd_i,
  input  logic [NUM_TAGS-1:0]  tagRelease_i,
  output logic                 stall_o,
  output logic                 valid_o,
  output logic [PKT_W-1:0]     packet0_o,
  output logic [PKT_W-1:0]     packet1_o,
  output logic [PKT_W-1:0]     packet2_o,
  output logic [PKT_W-1:0]     packet3_o,
  output logic [TAG_LOG-1:0]   tag0_o,
  output logic [TAG_LOG-1:0]   tag1_o,
  output logic [TAG_LOG-1:0]   tag2_o,
  output logic [TAG_LOG-1:0]   tag3_o,
  output logic [3:0]           tagValid_o,
  output logic [TAG_LOG:0]     freeCount_o
);

  logic [NUM_TAGS-1:0] free_vec_q, free_vec_d;
  logic [TAG_LOG:0]    free_count_q, free_count_d;
  logic                valid_q, valid_d;
  logic [PKT_W-1:0]    pkt_q [4];
  logic [PKT_W-1:0]    pkt_d [4];
  logic [TAG_LOG-1:0]  tag_q [4];
  logic [TAG_LOG-1:0]  tag_d [4];
  logic [3:0]          tag_valid_q, tag_valid_d;

  logic [PKT_W-1:0]    pkt_in [4];
  logic [TAG_LOG-1:0]  tag_sel [4];
  logic [NUM_TAGS-1:0] alloc_vec;
  logic [NUM_TAGS-1:0] avail;
  logic [TAG_LOG:0]    need;
  logic                found;
  logic                shortage;
  logic                accept;

  assign pkt_in[0] = packet0_i;
  assign pkt_in[1] = packet1_i;
  assign pkt_in[2] = packet2_i;
  assign pkt_in[3] = packet3_i;

  // Tag selection sees only the registered pool; releases this cycle become usable next cycle.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    avail     = free_vec_q;
    alloc_vec = '0;
    need      = '0;
    found     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tag_sel[k] = '0;
      found      = 1'b0;
      if (branchMask_i[k]) begin
        need = need + 1'b1;
        for (int t = 0; t < NUM_TAGS; t++) begin
          if (!found && avail[t]) begin
            tag_sel[k]   = TAG_LOG'(t);
            avail[t]     = 1'b0;
            alloc_vec[t] = 1'b1;
            found        = 1'b1;
          end
        end
      end
    end
  end

  assign shortage = ibReady_i & (need > free_count_q);
  assign stall_o  = stallBackEnd_i | shortage;
  assign accept   = ibReady_i & ~stall_o & ~flush_i;

  always_comb begin
    free_vec_d   = free_vec_q;
    valid_d      = valid_q;
    pkt_d        = pkt_q;
    tag_d        = tag_q;
    tag_valid_d  = tag_valid_q;
    if (flush_i) begin
      free_vec_d  = '1;
      valid_d     = 1'b0;
      tag_valid_d = '0;
    end else if (stallBackEnd_i) begin
      free_vec_d = free_vec_q | tagRelease_i;
    end else if (accept) begin
      valid_d     = 1'b1;
      pkt_d       = pkt_in;
      tag_d       = tag_sel;
      tag_valid_d = branchMask_i;
      free_vec_d  = (free_vec_q & ~alloc_vec) | tagRelease_i;
    end else begin
      valid_d    = 1'b0;
      free_vec_d = free_vec_q | tagRelease_i;
    end
    free_count_d = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      free_count_d = free_count_d + (TAG_LOG+1)'(free_vec_d[t]);
    end
  end

  // Packet and tag storage is cleared on reset as well, so the outputs read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_vec_q   <= '1;
      free_count_q <= (TAG_LOG+1)'(NUM_TAGS);
      valid_q      <= 1'b0;
      tag_valid_q  <= '0;
      for (int k = 0; k < 4; k++) begin
        pkt_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value.
      free_vec_q   <= free_vec_d;
      free_count_q <= free_count_d;
      valid_q      <= valid_d;
      tag_valid_q  <= tag_valid_d;
      pkt_q        <= pkt_d;
      tag_q        <= tag_d;
    end
  end

  assign valid_o     = valid_q;
  assign packet0_o   = pkt_q[0];
  assign packet1_o   = pkt_q[1];
  assign packet2_o   = pkt_q[2];
  assign packet3_o   = pkt_q[3];
  assign tag0_o      = tag_q[0];
  assign tag1_o      = tag_q[1];
  assign tag2_o      = tag_q[2];
  assign tag3_o      = tag_q[3];
  assign tagValid_o  = tag_valid_q;
  assign freeCount_o = free_count_q;

endmodule

// File: tb/tb_branch_tag_dispatch.sv
// Directed bench for branch_tag_dispatch: tag allocation order, pool shortage,
// back-end stall hold, flush and asynchronous reset.
module tb_branch_tag_dispatch;

  localparam int PKT_W    = 96;
  localparam int NUM_TAGS = 8;
  localparam int TAG_LOG  = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush_i;
  logic                ibReady_i;
  logic [PKT_W-1:0]    packet0_i, packet1_i, packet2_i, packet3_i;
  logic [3:0]          branchMask_i;
  logic                stallBackEnd_i;
  logic [NUM_TAGS-1:0] tagRelease_i;
  logic                stall_o;
  logic                valid_o;
  logic [PKT_W-1:0]    packet0_o, packet1_o, packet2_o, packet3_o;
  logic [TAG_LOG-1:0]  tag0_o, tag1_o, tag2_o, tag3_o;
  logic [3:0]          tagValid_o;
  logic [TAG_LOG:0]    freeCount_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_tag_dispatch #(.PKT_W(PKT_W), .NUM_TAGS(NUM_TAGS), .TAG_LOG(TAG_LOG)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .ibReady_i(ibReady_i),
    .packet0_i(packet0_i), .packet1_i(packet1_i), .packet2_i(packet2_i), .packet3_i(packet3_i),
    .branchMask_i(branchMask_i), .stallBackEnd_i(stallBackEnd_i), .tagRelease_i(tagRelease_i),
    .stall_o(stall_o), .valid_o(valid_o),
    .packet0_o(packet0_o), .packet1_o(packet1_o), .packet2_o(packet2_o), .packet3_o(packet3_o),
    .tag0_o(tag0_o), .tag1_o(tag1_o), .tag2_o(tag2_o), .tag3_o(tag3_o),
    .tagValid_o(tagValid_o), .freeCount_o(freeCount_o)
  );

  function automatic logic [PKT_W-1:0] pk(input int g, input int s);
    return {32'(g), 32'(s), 32'hDEAD_BEEF};
  endfunction

  function automatic logic [4*PKT_W-1:0] pk4(input int g);
    return {pk(g, 3), pk(g, 2), pk(g, 1), pk(g, 0)};
  endfunction

  task automatic drive(input logic rdy, input logic [3:0] mask, input int g,
                       input logic [NUM_TAGS-1:0] rel, input logic sbe, input logic fl);
    ibReady_i      = rdy;
    branchMask_i   = mask;
    packet0_i      = pk(g, 0);
    packet1_i      = pk(g, 1);
    packet2_i      = pk(g, 2);
    packet3_i      = pk(g, 3);
    tagRelease_i   = rel;
    stallBackEnd_i = sbe;
    flush_i        = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b0, 4'b0000, 0, '0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset valid: got %0b want 0", valid_o); end
    n_vec++;
    if (freeCount_o !== 4'd8) begin n_err++; $display("FAIL reset freeCount: got %0d want 8", freeCount_o); end
    n_vec++;
    if ({tag3_o, tag2_o, tag1_o, tag0_o, tagValid_o} !== 16'h0000) begin
      n_err++; $display("FAIL reset tags: got %h want 0000", {tag3_o, tag2_o, tag1_o, tag0_o, tagValid_o});
    end
    n_vec++;
    if ({packet3_o, packet2_o, packet1_o, packet0_o} !== '0) begin
      n_err++; $display("FAIL reset packets: got %h want 0", packet0_o);
    end
    n_vec++;
    if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset stall: got %0b want 0", stall_o); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    drive(1'b1, 4'b0101, 1, '0, 1'b0, 1'b0);
    n_vec++;
    if (stall_o !== 1'b0) begin n_err++; $display("FAIL basic stall: got %0b want 0", stall_o); end
    tick();
    drive(1'b0, 4'b0000, 0, '0, 1'b0, 1'b0);
    n_vec++;
    if (valid_o !== 1'b1) begin n_err++; $display("FAIL basic valid: got %0b want 1", valid_o); end
    n_vec++;
    if ({tag3_o, tag2_o, tag1_o, tag0_o} !== {3'd0, 3'd1, 3'd0, 3'd0}) begin
      n_err++; $display("FAIL basic tags: got %0d %0d %0d %0d want 0 1 0 0", tag3_o, tag2_o, tag1_o, tag0_o);
    end
    n_vec++;
    if (tagValid_o !== 4'b0101) begin n_err++; $display("FAIL basic tagValid: got %b want 0101", tagValid_o); end
    n_vec++;
    if (freeCount_o !== 4'd6) begin n_err++; $display("FAIL basic freeCount: got %0d want 6", freeCount_o); end
    n_vec++;
    if ({packet3_o, packet2_o, packet1_o, packet0_o} !== pk4(1)) begin
      n_err++; $display("FAIL basic packets: got %h want %h", packet0_o, pk(1, 0));
    end
    tick();
    n_vec++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL idle valid: got %0b want 0", valid_o); end
    drive(1'b0, 4'b0000, 0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'b0000, 0, '0, 1'b0, 1'b0);
    n_vec++;
    if (freeCount_o !== 4'd8) begin n_err++; $display("FAIL refill freeCount: got %0d want 8", freeCount_o); end
  endtask

  task automatic test_shortage;
    drive(1'b1, 4'b1111, 2, '0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if ({tag3_o, tag2_o, tag1_o, tag0_o, freeCount_o} !== {3'd3, 3'd2, 3'd1, 3'd0, 4'd4}) begin
      n_err++; $display("FAIL group2 tags/free: got %0d %0d %0d %0d free %0d want 3 2 1 0 free 4",
                        tag3_o, tag2_o, tag1_o, tag0_o, freeCount_o);
    end
    drive(1'b1, 4'b1111, 3, '0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if ({tag3_o, tag2_o, tag1_o, tag0_o, freeCount_o} !== {3'd7, 3'd6, 3'd5, 3'd4, 4'd0}) begin
      n_err++; $display("FAIL group3 tags/free: got %0d %0d %0d %0d free %0d want 7 6 5 4 free 0",
                        tag3_o, tag2_o, tag1_o, tag0_o, freeCount_o);
    end
    drive(1'b1, 4'b1111, 4, '0, 1'b0, 1'b0);
    n_vec++;
    if (stall_o !== 1'b1) begin n_err++; $display("FAIL short stall: got %0b want 1", stall_o); end
    tick();
    n_vec++;
    if ({valid_o, freeCount_o} !== {1'b0, 4'd0}) begin
      n_err++; $display("FAIL short hold: got valid %0b free %0d want valid 0 free 0", valid_o, freeCount_o);
    end
    drive(1'b1, 4'b1111, 4, 8'b0000_0110, 1'b0, 1'b0);
    n_vec++;
    if (stall_o !== 1'b1) begin n_err++; $display("FAIL release same-cycle stall: got %0b want 1", stall_o); end
    tick();
    drive(1'b1, 4'b1111, 4, 8'b1001_0000, 1'b0, 1'b0);
    n_vec++;
    if ({valid_o, freeCount_o, stall_o} !== {1'b0, 4'd2, 1'b1}) begin
      n_err++; $display("FAIL two free: got valid %0b free %0d stall %0b want 0 2 1", valid_o, freeCount_o, stall_o);
    end
    tick();
    drive(1'b1, 4'b1111, 4, '0, 1'b0, 1'b0);
    n_vec++;
    if ({freeCount_o, stall_o} !== {4'd4, 1'b0}) begin
      n_err++; $display("FAIL four free: got free %0d stall %0b want 4 0", freeCount_o, stall_o);
    end
    tick();
    n_vec++;
    if ({valid_o, tag3_o, tag2_o, tag1_o, tag0_o, freeCount_o} !== {1'b1, 3'd7, 3'd4, 3'd2, 3'd1, 4'd0}) begin
      n_err++; $display("FAIL regrant: got valid %0b tags %0d %0d %0d %0d free %0d want 1 7 4 2 1 0",
                        valid_o, tag3_o, tag2_o, tag1_o, tag0_o, freeCount_o);
    end
    n_vec++;
    if ({packet3_o, packet2_o, packet1_o, packet0_o} !== pk4(4)) begin
      n_err++; $display("FAIL regrant packets: got %h want %h", packet0_o, pk(4, 0));
    end
  endtask

  task automatic test_backend_stall;
    logic [NUM_TAGS-1:0] rel [3];
    logic [TAG_LOG:0]    exp_free [3];
    rel[0] = 8'b0000_1001; exp_free[0] = 4'd2;
    rel[1] = 8'b0010_0000; exp_free[1] = 4'd3;
    rel[2] = 8'b0000_0000; exp_free[2] = 4'd3;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'b0001, 5, rel[c], 1'b1, 1'b0);
      n_vec++;
      if (stall_o !== 1'b1) begin n_err++; $display("FAIL backend stall_o cyc%0d: got %0b want 1", c, stall_o); end
      tick();
      n_vec++;
      if ({valid_o, tag3_o, tag2_o, tag1_o, tag0_o, tagValid_o} !== {1'b1, 3'd7, 3'd4, 3'd2, 3'd1, 4'b1111}
          || {packet3_o, packet2_o, packet1_o, packet0_o} !== pk4(4)) begin
        n_err++; $display("FAIL backend hold cyc%0d: got valid %0b tags %0d %0d %0d %0d want 1 7 4 2 1",
                          c, valid_o, tag3_o, tag2_o, tag1_o, tag0_o);
      end
      n_vec++;
      if (freeCount_o !== exp_free[c]) begin
        n_err++; $display("FAIL backend freeCount cyc%0d: got %0d want %0d", c, freeCount_o, exp_free[c]);
      end
    end
    drive(1'b1, 4'b0000, 6, '0, 1'b0, 1'b0);
    n_vec++;
    if (stall_o !== 1'b0) begin n_err++; $display("FAIL nobranch stall: got %0b want 0", stall_o); end
    tick();
    n_vec++;
    if ({valid_o, tagValid_o, tag3_o, tag2_o, tag1_o, tag0_o, freeCount_o} !== {1'b1, 4'b0000, 12'd0, 4'd3}) begin
      n_err++; $display("FAIL nobranch accept: got valid %0b tv %b free %0d want 1 0000 3", valid_o, tagValid_o, freeCount_o);
    end
  endtask

  task automatic test_flush;
    drive(1'b1, 4'b0011, 7, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'b0000, 0, '0, 1'b0, 1'b0);
    n_vec++;
    if ({valid_o, tagValid_o, freeCount_o} !== {1'b0, 4'b0000, 4'd8}) begin
      n_err++; $display("FAIL flush: got valid %0b tv %b free %0d want 0 0000 8", valid_o, tagValid_o, freeCount_o);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 4'b0011, 8, '0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if ({valid_o, tag1_o, tag0_o, freeCount_o} !== {1'b1, 3'd1, 3'd0, 4'd6}) begin
      n_err++; $display("FAIL pre-reset accept: got valid %0b tags %0d %0d free %0d want 1 1 0 6",
                        valid_o, tag1_o, tag0_o, freeCount_o);
    end
    drive(1'b1, 4'b1000, 9, '0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({valid_o, tagValid_o, tag1_o, tag0_o, freeCount_o} !== {1'b0, 4'b0000, 3'd0, 3'd0, 4'd8}
        || {packet3_o, packet2_o, packet1_o, packet0_o} !== '0) begin
      n_err++; $display("FAIL async reset: got valid %0b tv %b free %0d want 0 0000 8", valid_o, tagValid_o, freeCount_o);
    end
    #1;
    reset = 1'b1;
    drive(1'b1, 4'b0100, 10, '0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if ({valid_o, tag2_o, tagValid_o, freeCount_o} !== {1'b1, 3'd0, 4'b0100, 4'd7}) begin
      n_err++; $display("FAIL post-reset grant: got valid %0b tag2 %0d tv %b free %0d want 1 0 0100 7",
                        valid_o, tag2_o, tagValid_o, freeCount_o);
    end
    drive(1'b0, 4'b0000, 0, '0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if ({valid_o, freeCount_o} !== {1'b0, 4'd7}) begin
      n_err++; $display("FAIL not-ready: got valid %0b free %0d want 0 7", valid_o, freeCount_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shortage();
    test_backend_stall();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
